// File: rtl/conv_pkg.sv
// Shared definitions for the convolution engine: FSM state encoding,
// output-size arithmetic and counter-width sizing.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_F = 3'd2,
        ST_MAC    = 3'd3,
        ST_EMIT   = 3'd4,
        ST_DONE   = 3'd5
    } conv_state_e;

    // Spatial size of a valid (no padding, stride 1) convolution.
    function automatic int conv_out_dim(input int in_dim, input int k);
        return in_dim - k + 1;
    endfunction

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int conv_cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate slice. The product and the running sum keep
// only the low BITWIDTH bits, so overflow wraps. acc_next exposes the value
// the accumulator takes at the next edge so the final sum can be captured
// in the same cycle as the last product.
module conv_mac #(
    parameter int BITWIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       en,
    input  logic signed [BITWIDTH-1:0] a,
    input  logic signed [BITWIDTH-1:0] b,
    output logic signed [BITWIDTH-1:0] acc_next
);

    logic signed [BITWIDTH-1:0] prod_s;
    logic signed [BITWIDTH-1:0] acc_next_s;
    logic signed [BITWIDTH-1:0] acc_r;

    // Next accumulator value: clear wins over accumulate.
    always_comb begin
        prod_s = a * b;
        if (clear) begin
            acc_next_s = {BITWIDTH{1'b0}};
        end else if (en) begin
            acc_next_s = acc_r + prod_s;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {BITWIDTH{1'b0}};
        end else begin
            acc_r <= acc_next_s;
        end
    end

    assign acc_next = acc_next_s;

endmodule

// File: rtl/conv_layer_engine.sv
// Time-multiplexed multi-channel 2-D convolution engine (valid, stride 1).
// Weights then a feature map are loaded over valid/ready streams into flat
// register buffers; each output is computed with one MAC per cycle and
// streamed out with backpressure.
// Optional build macro CONV_RELU_EN clamps negative results to zero.
module conv_layer_engine
    import conv_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int IN_CH    = 2,
    parameter int OUT_CH   = 2,
    parameter int IN_DIM   = 14,
    parameter int K        = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic                wt_valid,
    output logic                wt_ready,
    input  logic [BITWIDTH-1:0] wt_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] out_data,
    output logic                out_last
);

    localparam int OUT_DIM = conv_out_dim(IN_DIM, K);
    localparam int NW      = OUT_CH * IN_CH * K * K;
    localparam int NF      = IN_CH * IN_DIM * IN_DIM;
    localparam int NLD     = (NW > NF) ? NW : NF;
    localparam int LD_W    = conv_cnt_w(NLD);
    localparam int WA_W    = conv_cnt_w(NW);
    localparam int FA_W    = conv_cnt_w(NF);
    localparam int IC_W    = conv_cnt_w(IN_CH);
    localparam int OC_W    = conv_cnt_w(OUT_CH);
    localparam int K_W     = conv_cnt_w(K);
    localparam int OD_W    = conv_cnt_w(OUT_DIM);

    conv_state_e state_r;
    logic busy_r, done_r, wt_ready_r, in_ready_r, out_valid_r, out_last_r;
    logic [BITWIDTH-1:0] out_data_r;
    logic [LD_W-1:0] ld_r;
    logic [IC_W-1:0] ic_r;
    logic [K_W-1:0]  kr_r, kc_r;
    logic [OC_W-1:0] oc_r;
    logic [OD_W-1:0] r_r, c_r;

    // Buffers hold no reset value; they are always fully rewritten by a run.
    logic signed [BITWIDTH-1:0] wbuf_r [NW];
    logic signed [BITWIDTH-1:0] fbuf_r [NF];

    logic [WA_W-1:0] waddr_s;
    logic [FA_W-1:0] faddr_s;
    logic mac_clear_s, mac_en_s, last_tap_s, last_out_s, last_ld_s;
    logic signed [BITWIDTH-1:0] acc_next_s;
    logic [BITWIDTH-1:0] res_s;

    // Buffer addresses of the current tap and end-of-sequence flags.
    always_comb begin
        waddr_s = WA_W'((((int'(oc_r) * IN_CH + int'(ic_r)) * K + int'(kr_r)) * K) + int'(kc_r));
        faddr_s = FA_W'(int'(ic_r) * IN_DIM * IN_DIM + (int'(r_r) + int'(kr_r)) * IN_DIM
                        + int'(c_r) + int'(kc_r));
        last_tap_s = (ic_r == IC_W'(IN_CH - 1)) && (kr_r == K_W'(K - 1)) && (kc_r == K_W'(K - 1));
        last_out_s = (oc_r == OC_W'(OUT_CH - 1)) && (r_r == OD_W'(OUT_DIM - 1))
                     && (c_r == OD_W'(OUT_DIM - 1));
        last_ld_s  = (ld_r == LD_W'(NF - 1));
    end

    // Clear the accumulator on every entry into MAC; accumulate only in MAC.
    always_comb begin
        mac_en_s = (state_r == ST_MAC);
        if ((state_r == ST_LOAD_F) && in_valid && in_ready_r && last_ld_s) begin
            mac_clear_s = 1'b1;
        end else if ((state_r == ST_EMIT) && out_valid_r && out_ready && !out_last_r) begin
            mac_clear_s = 1'b1;
        end else begin
            mac_clear_s = 1'b0;
        end
    end

    conv_mac #(
        .BITWIDTH (BITWIDTH)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (mac_clear_s),
        .en       (mac_en_s),
        .a        (fbuf_r[faddr_s]),
        .b        (wbuf_r[waddr_s]),
        .acc_next (acc_next_s)
    );

    // Result shaping applied to the value presented in EMIT.
    always_comb begin
`ifdef CONV_RELU_EN
        res_s = acc_next_s[BITWIDTH-1] ? {BITWIDTH{1'b0}} : acc_next_s;
`else
        res_s = acc_next_s;
`endif
    end

    // Buffer writes on accepted load handshakes.
    always_ff @(posedge clk) begin
        if (wt_valid && wt_ready_r) begin
            wbuf_r[WA_W'(ld_r)] <= wt_data;
        end
        if (in_valid && in_ready_r) begin
            fbuf_r[FA_W'(ld_r)] <= in_data;
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            wt_ready_r  <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {BITWIDTH{1'b0}};
            ld_r        <= {LD_W{1'b0}};
            ic_r        <= {IC_W{1'b0}};
            kr_r        <= {K_W{1'b0}};
            kc_r        <= {K_W{1'b0}};
            oc_r        <= {OC_W{1'b0}};
            r_r         <= {OD_W{1'b0}};
            c_r         <= {OD_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_LOAD_W;
                        busy_r     <= 1'b1;
                        wt_ready_r <= 1'b1;
                        ld_r       <= {LD_W{1'b0}};
                    end
                end
                ST_LOAD_W: begin
                    if (wt_valid && wt_ready_r) begin
                        if (ld_r == LD_W'(NW - 1)) begin
                            ld_r       <= {LD_W{1'b0}};
                            wt_ready_r <= 1'b0;
                            in_ready_r <= 1'b1;
                            state_r    <= ST_LOAD_F;
                        end else begin
                            ld_r <= ld_r + LD_W'(1);
                        end
                    end
                end
                ST_LOAD_F: begin
                    if (in_valid && in_ready_r) begin
                        if (last_ld_s) begin
                            ld_r       <= {LD_W{1'b0}};
                            in_ready_r <= 1'b0;
                            state_r    <= ST_MAC;
                            ic_r       <= {IC_W{1'b0}};
                            kr_r       <= {K_W{1'b0}};
                            kc_r       <= {K_W{1'b0}};
                            oc_r       <= {OC_W{1'b0}};
                            r_r        <= {OD_W{1'b0}};
                            c_r        <= {OD_W{1'b0}};
                        end else begin
                            ld_r <= ld_r + LD_W'(1);
                        end
                    end
                end
                ST_MAC: begin
                    if (last_tap_s) begin
                        state_r     <= ST_EMIT;
                        out_valid_r <= 1'b1;
                        out_data_r  <= res_s;
                        out_last_r  <= last_out_s;
                        ic_r        <= {IC_W{1'b0}};
                        kr_r        <= {K_W{1'b0}};
                        kc_r        <= {K_W{1'b0}};
                    end else if (kc_r == K_W'(K - 1)) begin
                        kc_r <= {K_W{1'b0}};
                        if (kr_r == K_W'(K - 1)) begin
                            kr_r <= {K_W{1'b0}};
                            ic_r <= ic_r + IC_W'(1);
                        end else begin
                            kr_r <= kr_r + K_W'(1);
                        end
                    end else begin
                        kc_r <= kc_r + K_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (out_last_r) begin
                            out_last_r <= 1'b0;
                            done_r     <= 1'b1;
                            busy_r     <= 1'b0;
                            state_r    <= ST_DONE;
                        end else begin
                            state_r <= ST_MAC;
                            if (c_r == OD_W'(OUT_DIM - 1)) begin
                                c_r <= {OD_W{1'b0}};
                                if (r_r == OD_W'(OUT_DIM - 1)) begin
                                    r_r  <= {OD_W{1'b0}};
                                    oc_r <= oc_r + OC_W'(1);
                                end else begin
                                    r_r <= r_r + OD_W'(1);
                                end
                            end else begin
                                c_r <= c_r + OD_W'(1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    wt_ready_r  <= 1'b0;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign wt_ready  = wt_ready_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_conv_layer_engine.sv
// Self-checking bench for conv_layer_engine: a default-size engine and a
// small (1 in, 3 out, 6x6, 3x3) engine share the input streams; a mux picks
// whichever one is being exercised. Expected results come from a direct
// nested-loop convolution over the loaded words.
module tb_conv_layer_engine;

    logic clk = 1'b0;
    logic rst_n;
    logic start_a, start_b;
    logic wt_valid, in_valid, out_ready;
    logic [31:0] wt_data, in_data;

    logic busy_a, done_a, wt_ready_a, in_ready_a, out_valid_a, out_last_a;
    logic busy_b, done_b, wt_ready_b, in_ready_b, out_valid_b, out_last_b;
    logic [31:0] out_data_a, out_data_b;

    bit sel;
    logic busy_m, done_m, wt_ready_m, in_ready_m, out_valid_m, out_last_m;
    logic [31:0] out_data_m;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int ref_cyc = 0;

    logic [31:0] wq[$];
    logic [31:0] pq[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] ref_q[$];
    bit          last_q[$];

    typedef struct {
        int          oc;
        int          r;
        int          c;
        logic [31:0] val;
    } spot_t;

    conv_layer_engine u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_a),
        .busy      (busy_a),
        .done      (done_a),
        .wt_valid  (wt_valid),
        .wt_ready  (wt_ready_a),
        .wt_data   (wt_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_data   (in_data),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_data  (out_data_a),
        .out_last  (out_last_a)
    );

    conv_layer_engine #(
        .BITWIDTH (32),
        .IN_CH    (1),
        .OUT_CH   (3),
        .IN_DIM   (6),
        .K        (3)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .busy      (busy_b),
        .done      (done_b),
        .wt_valid  (wt_valid),
        .wt_ready  (wt_ready_b),
        .wt_data   (wt_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_data   (in_data),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_data  (out_data_b),
        .out_last  (out_last_b)
    );

    assign busy_m      = sel ? busy_b      : busy_a;
    assign done_m      = sel ? done_b      : done_a;
    assign wt_ready_m  = sel ? wt_ready_b  : wt_ready_a;
    assign in_ready_m  = sel ? in_ready_b  : in_ready_a;
    assign out_valid_m = sel ? out_valid_b : out_valid_a;
    assign out_last_m  = sel ? out_last_b  : out_last_a;
    assign out_data_m  = sel ? out_data_b  : out_data_a;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Plain convolution over the loaded words, [oc][r][c] order.
    function automatic void model(input int icn, input int ocn, input int dim, input int k);
        int od;
        logic [31:0] acc;
        od = dim - k + 1;
        exp_q.delete();
        for (int oc = 0; oc < ocn; oc++)
            for (int r = 0; r < od; r++)
                for (int c = 0; c < od; c++) begin
                    acc = 32'd0;
                    for (int ic = 0; ic < icn; ic++)
                        for (int kr = 0; kr < k; kr++)
                            for (int kc = 0; kc < k; kc++)
                                acc = acc + pq[ic*dim*dim + (r+kr)*dim + (c+kc)]
                                          * wq[((oc*icn + ic)*k + kr)*k + kc];
`ifdef CONV_RELU_EN
                    if (acc[31]) acc = 32'd0;
`endif
                    exp_q.push_back(acc);
                end
    endfunction

    task automatic build_directed(input logic [31:0] fm1_30);
        wq.delete();
        pq.delete();
        for (int oc = 0; oc < 2; oc++)
            for (int ic = 0; ic < 2; ic++)
                for (int t = 0; t < 25; t++)
                    wq.push_back((oc == 0) ? ((ic == 0) ? 32'd1 : 32'd0)
                                           : ((ic == 0) ? 32'd2 : 32'd3));
        for (int i = 0; i < 392; i++) pq.push_back(32'd0);
        pq[0]         = 32'd1;
        pq[196]       = 32'd5;
        pq[3*14]      = 32'd10;
        pq[196 + 3*14] = fm1_30;
    endtask

    task automatic feed(input bit is_w, input bit gaps);
        int idx = 0;
        int wc = 0;
        int n;
        bit v;
        n = is_w ? wq.size() : pq.size();
        while (idx < n && wc < 20000) begin
            @(negedge clk);
            wc++;
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (is_w) begin
                wt_valid = v;
                wt_data  = wq[idx];
                if (v && wt_ready_m) idx++;
            end else begin
                in_valid = v;
                in_data  = pq[idx];
                if (v && in_ready_m) begin
                    idx++;
                    ref_cyc = cyc;
                end
            end
        end
        chk(is_w ? "feed_w_count" : "feed_f_count", 32'(idx), 32'(n));
        @(negedge clk);
        wt_valid = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic collect(input int n, input bit bp, input int taps);
        int got = 0;
        int wc = 0;
        bit hold = 1'b0;
        bit rdy;
        logic [31:0] hd;
        while (got < n && wc < 1000) begin
            @(negedge clk);
            wc++;
            if (hold) begin
                chk("hold_valid", 32'(out_valid_m), 32'd1);
                chk("hold_data", out_data_m, hd);
            end
            if (out_valid_m) begin
                if (!hold) chk("latency", 32'(cyc - ref_cyc), 32'(taps + 1));
                rdy = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
                out_ready = rdy;
                if (rdy) begin
                    got_q.push_back(out_data_m);
                    last_q.push_back(out_last_m);
                    ref_cyc = cyc;
                    got++;
                    hold = 1'b0;
                    wc = 0;
                end else begin
                    hold = 1'b1;
                    hd = out_data_m;
                end
            end else begin
                out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b0;
                hold = 1'b0;
            end
        end
        chk("result_count", 32'(got), 32'(n));
    endtask

    task automatic run(input bit s, input bit gaps, input bit bp,
                       input int icn, input int ocn, input int dim, input int k);
        int n;
        model(icn, ocn, dim, k);
        n = exp_q.size();
        got_q.delete();
        last_q.delete();
        sel = s;
        @(negedge clk);
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        chk("busy_after_start", 32'(busy_m), 32'd1);
        feed(1'b1, gaps);
        feed(1'b0, gaps);
        collect(n, bp, icn * k * k);
        @(negedge clk);
        out_ready = 1'b0;
        chk("done_pulse", 32'(done_m), 32'd1);
        chk("busy_in_done", 32'(busy_m), 32'd0);
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        chk("done_single", 32'(done_m), 32'd0);
        chk("start_in_done_ignored", 32'(busy_m | wt_ready_m), 32'd0);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("res%0d", i), (i < got_q.size()) ? got_q[i] : 32'hDEADBEEF, exp_q[i]);
            chk($sformatf("last%0d", i), (i < last_q.size()) ? 32'(last_q[i]) : 32'hDEADBEEF,
                32'(i == n - 1));
        end
    endtask

    task automatic check_spots(input spot_t tab[], input string tag);
        int idx;
        for (int i = 0; i < tab.size(); i++) begin
            idx = tab[i].oc * 100 + tab[i].r * 10 + tab[i].c;
            chk($sformatf("%s_%0d_%0d_%0d", tag, tab[i].oc, tab[i].r, tab[i].c),
                (idx < got_q.size()) ? got_q[idx] : 32'hDEADBEEF, tab[i].val);
        end
    endtask

    initial begin
        spot_t tab_a[];
        spot_t tab_r[];
        tab_a = '{
            '{0, 0, 0, 32'd11}, '{1, 0, 0, 32'd22},
            '{0, 1, 0, 32'd10}, '{0, 2, 0, 32'd10}, '{0, 3, 0, 32'd10},
            '{1, 1, 0, 32'd5},  '{1, 2, 0, 32'd5},  '{1, 3, 0, 32'd5},
            '{0, 4, 0, 32'd0},  '{1, 0, 1, 32'd0},  '{0, 9, 9, 32'd0},
            '{1, 9, 9, 32'd0}
        };
`ifdef CONV_RELU_EN
        tab_r = '{'{1, 1, 0, 32'd0}, '{0, 1, 0, 32'd10}};
`else
        tab_r = '{'{1, 1, 0, 32'hFFFFFFD8}, '{0, 1, 0, 32'd10}};
`endif

        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        wt_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        wt_data = 32'd0; in_data = 32'd0;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_wt_ready", 32'(wt_ready_a), 32'd0);
        chk("rst_in_ready", 32'(in_ready_a), 32'd0);
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out_last", 32'(out_last_a), 32'd0);
        chk("rst_out_data", out_data_a, 32'd0);

        // Directed stimulus, no gaps, consumer always ready.
        build_directed(32'hFFFFFFFB);
        run(1'b0, 1'b0, 1'b0, 2, 2, 14, 5);
        check_spots(tab_a, "spot");
        ref_q = got_q;

        // Same stimulus with input gaps and random backpressure.
        build_directed(32'hFFFFFFFB);
        run(1'b0, 1'b1, 1'b1, 2, 2, 14, 5);
        for (int i = 0; i < 200; i++)
            chk($sformatf("same_seq%0d", i), (i < got_q.size()) ? got_q[i] : 32'hDEADBEEF,
                (i < ref_q.size()) ? ref_q[i] : 32'hDEADBEEF);

        // Wrap-around: every word 0x7FFFFFFF.
        wq.delete();
        pq.delete();
        for (int i = 0; i < 100; i++) wq.push_back(32'h7FFFFFFF);
        for (int i = 0; i < 392; i++) pq.push_back(32'h7FFFFFFF);
        run(1'b0, 1'b0, 1'b0, 2, 2, 14, 5);
        for (int i = 0; i < 200; i++)
            chk($sformatf("wrap%0d", i), (i < got_q.size()) ? got_q[i] : 32'hDEADBEEF, 32'h32);

        // Negative accumulation: raw -40 or clamped to zero.
        build_directed(32'hFFFFFFEC);
        run(1'b0, 1'b0, 1'b0, 2, 2, 14, 5);
        check_spots(tab_r, "neg");

        // Reset in the middle of MAC, with a start pulse while busy.
        build_directed(32'hFFFFFFFB);
        sel = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        feed(1'b1, 1'b0);
        feed(1'b0, 1'b0);
        repeat (5) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("busy_start_ignored", 32'(busy_a), 32'd1);
        chk("no_reload_on_start", 32'(wt_ready_a | in_ready_a), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy_a), 32'd0);
        chk("async_out", {29'd0, done_a, out_valid_a, out_last_a}, 32'd0);
        chk("async_ready", 32'(wt_ready_a | in_ready_a), 32'd0);
        chk("async_data", out_data_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("post_rst_idle", {28'd0, busy_a, out_valid_a, wt_ready_a, in_ready_a}, 32'd0);
        run(1'b0, 1'b0, 1'b0, 2, 2, 14, 5);
        check_spots(tab_a, "rerun");

        // Small configuration: all pixels 1, weights oc+1.
        wq.delete();
        pq.delete();
        for (int oc = 0; oc < 3; oc++)
            for (int t = 0; t < 9; t++) wq.push_back(32'(oc + 1));
        for (int i = 0; i < 36; i++) pq.push_back(32'd1);
        run(1'b1, 1'b1, 1'b1, 1, 3, 6, 3);
        for (int i = 0; i < 48; i++)
            chk($sformatf("small%0d", i), (i < got_q.size()) ? got_q[i] : 32'hDEADBEEF,
                32'(9 * (i / 16 + 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
